led_blink_code: RTL and testbench

LED_BLINK_CODE -- requirements
Module: led_blink_code

---
 rtl/led_blink_code.sv | 138 +++++++++++++
 tb/tb_led_blink_code.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/led_blink_code.sv
// LED blink-code generator: flashes a latched 4-bit code as a burst of pulses,
// then holds dark for a gap, optionally repeating the same code indefinitely.
module led_blink_code #(
    parameter int unsigned CLOCK_FREQ_MHZ = 250,
    parameter int unsigned ON_MSEC        = 200,
    parameter int unsigned OFF_MSEC       = 300,
    parameter int unsigned GAP_MSEC       = 1500
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic [3:0] CODE,
    input  logic       CODE_VALID,
    input  logic       REPEAT,
    output logic       LED_OUT,
    output logic       BUSY,
    output logic       DONE
);

    localparam int unsigned ON_CYC  = CLOCK_FREQ_MHZ * ON_MSEC * 1000;
    localparam int unsigned OFF_CYC = CLOCK_FREQ_MHZ * OFF_MSEC * 1000;
    localparam int unsigned GAP_CYC = CLOCK_FREQ_MHZ * GAP_MSEC * 1000;

    localparam int unsigned MAX_OO  = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
    localparam int unsigned MAX_CYC = (MAX_OO > GAP_CYC) ? MAX_OO : GAP_CYC;
    localparam int          CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    typedef logic [CNT_W-1:0] cnt_t;

    // Counter holds "cycles remaining after this one", so phase entry loads N-1.
    localparam cnt_t ON_LOAD  = cnt_t'(ON_CYC - 1);
    localparam cnt_t OFF_LOAD = cnt_t'(OFF_CYC - 1);
    localparam cnt_t GAP_LOAD = cnt_t'(GAP_CYC - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t     state, state_n;
    cnt_t       cnt, cnt_n;
    logic [3:0] pulses, pulses_n;
    logic [3:0] code_q, code_n;
    logic       led_n, busy_n, done_n;

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state   <= IDLE;
            cnt     <= '0;
            pulses  <= '0;
            code_q  <= '0;
            LED_OUT <= 1'b0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            pulses  <= pulses_n;
            code_q  <= code_n;
            LED_OUT <= led_n;
            BUSY    <= busy_n;
            DONE    <= done_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        pulses_n = pulses;
        code_n   = code_q;

        if (cnt != '0) begin
            cnt_n = cnt - cnt_t'(1);
        end

        case (state)
            IDLE: begin
                cnt_n = '0;
                if (CODE_VALID) begin
                    code_n   = CODE;
                    pulses_n = '0;
                    if (CODE != 4'd0) begin
                        state_n = ON;
                        cnt_n   = ON_LOAD;
                    end else begin
                        state_n = GAP;
                        cnt_n   = GAP_LOAD;
                    end
                end
            end
            ON: begin
                if (cnt == '0) begin
                    pulses_n = pulses + 4'd1;
                    if (pulses_n == code_q) begin
                        state_n = GAP;
                        cnt_n   = GAP_LOAD;
                    end else begin
                        state_n = OFF;
                        cnt_n   = OFF_LOAD;
                    end
                end
            end
            OFF: begin
                if (cnt == '0) begin
                    state_n = ON;
                    cnt_n   = ON_LOAD;
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    if (REPEAT) begin
                        pulses_n = '0;
                        if (code_q != 4'd0) begin
                            state_n = ON;
                            cnt_n   = ON_LOAD;
                        end else begin
                            cnt_n   = GAP_LOAD;
                        end
                    end else begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        led_n  = (state_n == ON);
        busy_n = (state_n != IDLE);
        done_n = (state_n == GAP) && (cnt_n == '0);
    end

endmodule

// File: tb/tb_led_blink_code.sv
// Directed bench for led_blink_code with shortened phases (ON=1000, OFF=1000, GAP=2000 cycles).
module tb_led_blink_code;

    logic       CLK = 1'b0;
    logic       RESETN = 1'b0;
    logic [3:0] CODE = '0;
    logic       CODE_VALID = 1'b0;
    logic       REPEAT = 1'b0;
    logic       LED_OUT, BUSY, DONE;

    int n_tests = 0;
    int n_fail  = 0;
    int runs[$];
    int done_cnt, first_done, last_done, cyc;

    led_blink_code #(
        .CLOCK_FREQ_MHZ(1),
        .ON_MSEC(1),
        .OFF_MSEC(1),
        .GAP_MSEC(2)
    ) dut (
        .CLK(CLK),
        .RESETN(RESETN),
        .CODE(CODE),
        .CODE_VALID(CODE_VALID),
        .REPEAT(REPEAT),
        .LED_OUT(LED_OUT),
        .BUSY(BUSY),
        .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // First edge is the acceptance edge; LED run lengths recorded (+high / -low) while BUSY.
    task automatic run_seq(input int budget, input int drop_rep_at, input int new_code_at);
        int   len;
        logic cur;
        len = 0;
        cur = 1'b0;
        runs.delete();
        done_cnt = 0; first_done = -1; last_done = -1; cyc = 0;
        while (cyc < budget) begin
            tick();
            cyc++;
            if (cyc == 1) CODE_VALID = 1'b0;
            if (cyc == drop_rep_at) REPEAT = 1'b0;
            if (cyc == new_code_at) CODE = 4'd5;
            if (!BUSY) break;
            if (DONE) begin
                done_cnt++;
                if (first_done < 0) first_done = cyc;
                last_done = cyc;
            end
            if (len > 0 && LED_OUT != cur) begin
                runs.push_back(cur ? len : -len);
                len = 0;
            end
            cur = LED_OUT;
            len++;
        end
        if (len > 0) runs.push_back(cur ? len : -len);
        check("seq_terminates", BUSY, 0);
    endtask

    task automatic check_runs(input string tag, input int code, input int reps);
        int exp_runs[$];
        for (int r = 0; r < reps; r++) begin
            if (code == 0) exp_runs.push_back(-2000);
            for (int p = 0; p < code; p++) begin
                exp_runs.push_back(1000);
                exp_runs.push_back((p == code - 1) ? -2000 : -1000);
            end
        end
        check({tag, "_nruns"}, runs.size(), exp_runs.size());
        for (int i = 0; i < exp_runs.size(); i++) begin
            check($sformatf("%s_run%0d", tag, i), (i < runs.size()) ? runs[i] : 0, exp_runs[i]);
        end
    endtask

    initial begin
        int k;
        int dn;

        // Reset with CODE_VALID asserted must not start anything
        CODE = 4'd3;
        CODE_VALID = 1'b1;
        repeat (3) tick();
        check("rst_led", LED_OUT, 0);
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);
        CODE_VALID = 1'b0;
        RESETN = 1'b1;
        tick();
        tick();
        check("idle_busy", BUSY, 0);

        // CODE=3, single shot
        CODE = 4'd3; CODE_VALID = 1'b1;
        run_seq(20000, -1, -1);
        check_runs("code3", 3, 1);
        check("code3_done_cnt", done_cnt, 1);
        check("code3_done_at", first_done, 7000);
        check("code3_busy_drop", cyc, 7001);

        // CODE=0: gap only
        CODE = 4'd0; CODE_VALID = 1'b1;
        run_seq(10000, -1, -1);
        check_runs("code0", 0, 1);
        check("code0_done_cnt", done_cnt, 1);
        check("code0_done_at", first_done, 2000);
        check("code0_busy_drop", cyc, 2001);

        // CODE=2 with REPEAT, dropped mid second run; CODE change ignored
        CODE = 4'd2; CODE_VALID = 1'b1; REPEAT = 1'b1;
        run_seq(30000, 6000, 100);
        check_runs("rep2", 2, 2);
        check("rep2_done_cnt", done_cnt, 2);
        check("rep2_first_done", first_done, 5000);
        check("rep2_last_done", last_done, 10000);
        check("rep2_busy_drop", cyc, 10001);

        // CODE=15: no pulse-count overflow
        CODE = 4'd15; CODE_VALID = 1'b1;
        run_seq(40000, -1, -1);
        check_runs("code15", 15, 1);
        check("code15_done_cnt", done_cnt, 1);
        check("code15_done_at", first_done, 31000);

        // Reset during the second ON of CODE=3, then immediate CODE=1
        CODE = 4'd3; CODE_VALID = 1'b1;
        dn = 0;
        for (int i = 1; i <= 2500; i++) begin
            tick();
            if (i == 1) CODE_VALID = 1'b0;
            if (DONE) dn++;
        end
        check("abort_mid_on_led", LED_OUT, 1);
        RESETN = 1'b0;
        tick();
        check("abort_led", LED_OUT, 0);
        check("abort_busy", BUSY, 0);
        check("abort_done", DONE, 0);
        check("abort_no_done", dn, 0);
        RESETN = 1'b1; CODE = 4'd1; CODE_VALID = 1'b1;
        run_seq(10000, -1, -1);
        check_runs("after_rst", 1, 1);
        check("after_rst_done_at", first_done, 3000);

        // CODE_VALID held: back-to-back with one IDLE cycle in between
        CODE = 4'd1; CODE_VALID = 1'b1;
        k = 0;
        while (!DONE && k < 5000) begin
            tick();
            k++;
        end
        check("held_done1", DONE, 1);
        check("held_done1_at", k, 3000);
        tick();
        check("held_idle_busy", BUSY, 0);
        check("held_idle_led", LED_OUT, 0);
        tick();
        check("held_restart_led", LED_OUT, 1);
        check("held_restart_busy", BUSY, 1);
        k = 1;
        while (!DONE && k < 5000) begin
            tick();
            k++;
        end
        check("held_done2_at", k, 3000);
        CODE_VALID = 1'b0;
        tick();
        check("held_end_busy", BUSY, 0);
        tick();
        check("held_stays_idle", BUSY, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
